// File: rtl/bus_read_sequencer.sv
// Scans a bank of registers sharing one tri-state read bus, one active-low select at a time,
// and presents each captured word on valid/ready. Optional macro: BUSRD_DOUBLE_SAMPLE_EN.
module bus_read_sequencer #(
    parameter int NrOfBits     = 8,
    parameter int NrOfRegs     = 4,
    parameter int SettleCycles = 1
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Tick,
    input  logic                        Start,
    input  logic [NrOfBits-1:0]         BusIn,
    input  logic                        DataReady,
    output logic [NrOfRegs-1:0]         cs,
    output logic [NrOfBits-1:0]         DataOut,
    output logic [$clog2(NrOfRegs)-1:0] DataIndex,
    output logic                        DataValid,
    output logic                        Busy,
    output logic                        Done,
    output logic                        Mismatch
);
    localparam int IW = $clog2(NrOfRegs);
    localparam int CW = $clog2(SettleCycles + 1);
    localparam logic [IW-1:0]       LastIdx    = IW'(NrOfRegs - 1);
    localparam logic [CW-1:0]       SettleInit = CW'(SettleCycles);
    localparam logic [NrOfRegs-1:0] OneHot0    = NrOfRegs'(1);

`ifdef BUSRD_DOUBLE_SAMPLE_EN
    typedef enum logic [1:0] {IDLE, SELECT, VERIFY, PRESENT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SELECT, PRESENT} state_t;
`endif

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NrOfRegs-1:0]   cs_d;
    logic [NrOfBits-1:0]   data_d;
    logic [IW-1:0]         didx_d;
    logic                  valid_d;
    logic                  busy_d;
    logic                  done_d;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
    logic                  mism_d;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            cs        <= '1;
            DataOut   <= '0;
            DataIndex <= '0;
            DataValid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
            Mismatch  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cs        <= cs_d;
            DataOut   <= data_d;
            DataIndex <= didx_d;
            DataValid <= valid_d;
            Busy      <= busy_d;
            Done      <= done_d;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
            Mismatch  <= mism_d;
`endif
        end
    end

`ifndef BUSRD_DOUBLE_SAMPLE_EN
    assign Mismatch = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = DataOut;
        didx_d  = DataIndex;
        done_d  = 1'b0;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
        mism_d  = Mismatch;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = SELECT;
                    idx_d   = '0;
                    cnt_d   = SettleInit;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
                    mism_d  = 1'b0;
`endif
                end
            end
            SELECT: begin
                // Settle count only advances on Tick; capture on the last qualified edge.
                if (Tick) begin
                    if (cnt_q == CW'(1)) begin
                        data_d = BusIn;
                        didx_d = idx_q;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
                        state_d = VERIFY;
`else
                        state_d = PRESENT;
`endif
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
`ifdef BUSRD_DOUBLE_SAMPLE_EN
            VERIFY: begin
                mism_d  = (BusIn != DataOut);
                state_d = PRESENT;
            end
`endif
            PRESENT: begin
                if (DataReady) begin
                    if (idx_q == LastIdx) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SELECT;
                        idx_d   = idx_q + IW'(1);
                        cnt_d   = SettleInit;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
                        mism_d  = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        cs_d = '1;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
        if (state_d == SELECT || state_d == VERIFY) cs_d = ~(OneHot0 << idx_d);
`else
        if (state_d == SELECT) cs_d = ~(OneHot0 << idx_d);
`endif
        valid_d = (state_d == PRESENT);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Directed bench for bus_read_sequencer: table-driven full scan plus hand-written corner sequences.
module tb_bus_read_sequencer;
    localparam int N = 4;
`ifdef BUSRD_DOUBLE_SAMPLE_EN
    localparam int MAC = 1;
`else
    localparam int MAC = 0;
`endif

    typedef struct {
        logic       tick;
        logic       ready;
        logic [3:0] cs;
        logic       valid;
        logic       busy;
        logic       done;
        logic       chk;
        logic [1:0] idx;
        logic [7:0] data;
    } row_t;

    logic Clock = 0, Reset = 0, Tick = 0, Start = 0, DataReady = 0;
    logic [7:0] BusIn, DataOut;
    logic [3:0] cs;
    logic [1:0] DataIndex;
    logic DataValid, Busy, Done, Mismatch;

    logic Start3 = 0, Tick3 = 0, DataReady3 = 0;
    logic [7:0] BusIn3, DataOut3;
    logic [3:0] cs3;
    logic [1:0] DataIndex3;
    logic DataValid3, Busy3, Done3, Mismatch3;

    logic [7:0] regs [N];
    logic [7:0] flip = 8'h00;
    int errors = 0, checks = 0;

    always #5 Clock = ~Clock;

    bus_read_sequencer #(.NrOfBits(8), .NrOfRegs(N), .SettleCycles(1)) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .BusIn(BusIn),
        .DataReady(DataReady), .cs(cs), .DataOut(DataOut), .DataIndex(DataIndex),
        .DataValid(DataValid), .Busy(Busy), .Done(Done), .Mismatch(Mismatch));

    bus_read_sequencer #(.NrOfBits(8), .NrOfRegs(N), .SettleCycles(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick3), .Start(Start3), .BusIn(BusIn3),
        .DataReady(DataReady3), .cs(cs3), .DataOut(DataOut3), .DataIndex(DataIndex3),
        .DataValid(DataValid3), .Busy(Busy3), .Done(Done3), .Mismatch(Mismatch3));

    // Register bank model: the selected register drives the bus.
    always_comb begin
        BusIn = 8'h00;
        for (int i = 0; i < N; i++) if (!cs[i]) BusIn = regs[i] ^ flip;
    end
    always_comb begin
        BusIn3 = 8'h00;
        for (int i = 0; i < N; i++) if (!cs3[i]) BusIn3 = regs[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!DataValid && n < 50) begin step(); n++; end
        check(name, DataValid, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!Done && n < 80) begin step(); n++; end
        check(name, Done, 1);
    endtask

    function automatic row_t mk(input logic t, input logic rd, input logic [3:0] c, input logic v,
                                input logic b, input logic d, input logic ck,
                                input logic [1:0] ix, input logic [7:0] dt);
        row_t r;
        r.tick = t; r.ready = rd; r.cs = c; r.valid = v; r.busy = b;
        r.done = d; r.chk = ck; r.idx = ix; r.data = dt;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[$];
        int done_cnt;
        int ticks;
        int c;

        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;

        // Reset state
        repeat (2) step();
        check("rst.cs", cs, 4'b1111);
        check("rst.valid", DataValid, 0);
        check("rst.busy", Busy, 0);
        check("rst.done", Done, 0);
        check("rst.data", DataOut, 0);
        check("rst.idx", DataIndex, 0);
        check("rst.mismatch", Mismatch, 0);
        check("rst.cs3", cs3, 4'b1111);
        Reset = 1;
        step();

        // Full scan table: one row per edge starting at the Start edge
        for (int k = 0; k < N; k++) begin
            rows.push_back(mk(1, 1, ~(4'b0001 << k), 0, 1, 0, 0, 2'd0, 8'h00));
            if (MAC != 0) rows.push_back(mk(1, 1, ~(4'b0001 << k), 0, 1, 0, 0, 2'd0, 8'h00));
            rows.push_back(mk(1, 1, 4'b1111, 1, 1, 0, 1, k[1:0], regs[k]));
        end
        rows.push_back(mk(1, 1, 4'b1111, 0, 0, 1, 0, 2'd0, 8'h00));
        rows.push_back(mk(1, 1, 4'b1111, 0, 0, 0, 0, 2'd0, 8'h00));

        Start = 1;
        foreach (rows[i]) begin
            Tick = rows[i].tick;
            DataReady = rows[i].ready;
            step();
            Start = 0;
            check($sformatf("scan[%0d].cs", i), cs, rows[i].cs);
            check($sformatf("scan[%0d].valid", i), DataValid, rows[i].valid);
            check($sformatf("scan[%0d].busy", i), Busy, rows[i].busy);
            check($sformatf("scan[%0d].done", i), Done, rows[i].done);
            check($sformatf("scan[%0d].mismatch", i), Mismatch, 0);
            if (rows[i].chk) begin
                check($sformatf("scan[%0d].idx", i), DataIndex, rows[i].idx);
                check($sformatf("scan[%0d].data", i), DataOut, rows[i].data);
            end
        end

        // Backpressure on word 1, with a Start pulse while busy
        DataReady = 0; Tick = 1; Start = 1;
        step();
        Start = 0;
        wait_valid("bp.word0.valid");
        check("bp.word0.idx", DataIndex, 0);
        DataReady = 1;
        step();
        DataReady = 0;
        wait_valid("bp.word1.valid");
        for (int k = 0; k < 5; k++) begin
            if (k == 2) Start = 1;
            step();
            Start = 0;
            check($sformatf("bp.hold[%0d].valid", k), DataValid, 1);
            check($sformatf("bp.hold[%0d].data", k), DataOut, 8'h22);
            check($sformatf("bp.hold[%0d].cs", k), cs, 4'b1111);
            check($sformatf("bp.hold[%0d].idx", k), DataIndex, 1);
        end
        DataReady = 1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (Done) done_cnt++;
        end
        check("busystart.done_count", done_cnt, 1);
        check("busystart.idle", Busy, 0);

        // Reset asserted mid-scan while register 2 is selected
        Tick = 1; DataReady = 1; Start = 1;
        step();
        Start = 0;
        c = 0;
        while (cs !== 4'b1011 && c < 50) begin step(); c++; end
        check("rstmid.reached_sel2", cs, 4'b1011);
        Tick = 0;
        step();
        check("rstmid.tick_hold", cs, 4'b1011);
        #2 Reset = 0;
        #1;
        check("rstmid.cs", cs, 4'b1111);
        check("rstmid.valid", DataValid, 0);
        check("rstmid.busy", Busy, 0);
        check("rstmid.done", Done, 0);
        check("rstmid.data", DataOut, 0);
        check("rstmid.idx", DataIndex, 0);
        @(negedge Clock);
        Reset = 1;
        Tick = 1; Start = 1;
        step();
        Start = 0;
        check("restart.cs", cs, 4'b1110);
        check("restart.busy", Busy, 1);
        wait_valid("restart.valid");
        check("restart.idx", DataIndex, 0);
        check("restart.data", DataOut, 8'h11);
        wait_done("restart.done");
        step();

        // Tick gating on the SettleCycles=3 instance
        Tick3 = 0; DataReady3 = 0; Start3 = 1;
        step();
        Start3 = 0;
        check("tick.sel.cs", cs3, 4'b1110);
        ticks = 0;
        c = 1;
        while (ticks < 3 && c < 40) begin
            Tick3 = (c % 4 == 0);
            step();
            if (Tick3) ticks++;
            if (ticks < 3) begin
                check($sformatf("tick.c%0d.cs", c), cs3, 4'b1110);
                check($sformatf("tick.c%0d.valid", c), DataValid3, 0);
            end
            c++;
        end
        Tick3 = 0;
        check("tick.count", ticks, 3);
`ifdef BUSRD_DOUBLE_SAMPLE_EN
        check("tick.verify.cs", cs3, 4'b1110);
        step();
`endif
        check("tick.capture.valid", DataValid3, 1);
        check("tick.capture.data", DataOut3, 8'h11);
        check("tick.capture.cs", cs3, 4'b1111);
        check("tick.capture.edge", c - 1, 12);

`ifdef BUSRD_DOUBLE_SAMPLE_EN
        // Bus changes between capture and the verify sample
        regs[0] = 8'h5A;
        Tick = 1; DataReady = 0; Start = 1;
        step();
        Start = 0;
        step();
        check("dbl.verify.cs", cs, 4'b1110);
        flip = 8'h01;
        step();
        flip = 8'h00;
        check("dbl.data", DataOut, 8'h5A);
        check("dbl.mismatch", Mismatch, 1);
        check("dbl.valid", DataValid, 1);
        DataReady = 1;
        step();
        check("dbl.clear.mismatch", Mismatch, 0);
        check("dbl.clear.cs", cs, 4'b1101);
        DataReady = 0;
        wait_valid("dbl.word1.valid");
        check("dbl.stable.mismatch", Mismatch, 0);
        check("dbl.stable.data", DataOut, 8'h22);
        DataReady = 1;
        wait_done("dbl.done");
`else
        // Without the double sample a changing bus never raises Mismatch
        regs[0] = 8'h5A;
        Tick = 1; DataReady = 0; Start = 1;
        step();
        Start = 0;
        step();
        flip = 8'h01;
        step();
        flip = 8'h00;
        check("single.data", DataOut, 8'h5A);
        check("single.mismatch", Mismatch, 0);
        DataReady = 1;
        wait_done("single.done");
`endif
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
